// File: rtl/fifo_ctrl_flags.sv
// Pointer, occupancy and status controller for a 2**AddrBits-entry register-file FIFO.
// Acks are combinational; pointers, count and every status flag are registered.
module fifo_ctrl_flags #(
    parameter int AddrBits       = 4,
    parameter int AlmostFullThr  = 12,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic                rd_i,
    input  logic                flush_i,
    input  logic                err_clr_i,
    output logic [AddrBits-1:0] w_addr_o,
    output logic [AddrBits-1:0] r_addr_o,
    output logic                wr_ack_o,
    output logic                rd_ack_o,
    output logic [AddrBits:0]   count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int Depth = 1 << AddrBits;
    localparam logic [AddrBits:0] DepthC = (AddrBits+1)'(Depth);
    localparam logic [AddrBits:0] AfThr  = (AddrBits+1)'(AlmostFullThr);
    localparam logic [AddrBits:0] AeThr  = (AddrBits+1)'(AlmostEmptyThr);

    generate
        if (AddrBits < 1 || AlmostFullThr < 1 || AlmostFullThr > Depth ||
            AlmostEmptyThr < 0 || AlmostEmptyThr > Depth - 1) begin : g_bad_param
            $error("fifo_ctrl_flags: illegal AddrBits or threshold parameter");
        end
    endgenerate

    logic [AddrBits-1:0] w_ptr_q, r_ptr_q;
    logic [AddrBits:0]   count_q, count_nxt;
    logic                full_q, empty_q, afull_q, aempty_q;
    logic                ovf_q, unf_q;
    logic                wr_ack, rd_ack;

    // A pop on a full FIFO frees a slot in the same cycle, so the push can ride along.
    assign rd_ack = ~flush_i & rd_i & ~empty_q;
    assign wr_ack = ~flush_i & wr_i & (~full_q | rd_ack);

    always_comb begin
        count_nxt = count_q;
        if (flush_i) begin
            count_nxt = '0;
        end else if (wr_ack && !rd_ack) begin
            count_nxt = count_q + 1'b1;
        end else if (rd_ack && !wr_ack) begin
            count_nxt = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            if (flush_i) begin
                w_ptr_q <= '0;
                r_ptr_q <= '0;
            end else begin
                if (wr_ack) w_ptr_q <= w_ptr_q + 1'b1;
                if (rd_ack) r_ptr_q <= r_ptr_q + 1'b1;
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == DepthC);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= AfThr);
            aempty_q <= (count_nxt <= AeThr);
        end
    end

    // Set has priority over clear; flush suppresses setting but does not clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (!flush_i && wr_i && !wr_ack) ovf_q <= 1'b1;
            else if (err_clr_i)              ovf_q <= 1'b0;
            if (!flush_i && rd_i && !rd_ack) unf_q <= 1'b1;
            else if (err_clr_i)              unf_q <= 1'b0;
        end
    end

    assign w_addr_o       = w_ptr_q;
    assign r_addr_o       = r_ptr_q;
    assign wr_ack_o       = wr_ack;
    assign rd_ack_o       = rd_ack;
    assign count_o        = count_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule
